// File: rtl/branch_predictor.sv
// Direct-mapped BTB with a 2-bit saturating direction counter per entry.
// Fetch looks up combinationally; execute trains the table on resolved branches/jumps.
module branch_predictor #(
  parameter int IDX_BITS = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] query_pc,
  output logic        pred_taken,
  output logic [31:0] pred_pc,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic [31:0] upd_target,
  input  logic        upd_taken,
  input  logic        upd_mispredict,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts
);

  localparam int ENTRIES = 1 << IDX_BITS;
  localparam int TAG_W   = 30 - IDX_BITS;

  logic [ENTRIES-1:0] valid;
  logic [TAG_W-1:0]   tag    [ENTRIES];
  logic [31:0]        target [ENTRIES];
  logic [1:0]         ctr    [ENTRIES];

  logic [IDX_BITS-1:0] q_idx;
  logic [IDX_BITS-1:0] u_idx;
  logic [TAG_W-1:0]    q_tag;
  logic [TAG_W-1:0]    u_tag;
  logic                q_hit;
  logic                u_hit;
  logic                unused_pc_bits;

  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == 2'b11) ? c : c + 2'd1;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    return (c == 2'b00) ? c : c - 2'd1;
  endfunction

  assign q_idx = query_pc[IDX_BITS+1:2];
  assign q_tag = query_pc[31:IDX_BITS+2];
  assign u_idx = upd_pc[IDX_BITS+1:2];
  assign u_tag = upd_pc[31:IDX_BITS+2];
  assign unused_pc_bits = ^upd_pc[1:0];

  assign q_hit = valid[q_idx] && (tag[q_idx] == q_tag);
  assign u_hit = valid[u_idx] && (tag[u_idx] == u_tag);

  // Lookup: no bypass from the update port, so a same-cycle update is not seen yet.
  always_comb begin
    pred_taken = 1'b0;
    pred_pc    = query_pc + 32'd4;
    if (rst && q_hit && ctr[q_idx][1]) begin
      pred_taken = 1'b1;
      pred_pc    = target[q_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr[i] <= 2'b01;
    end else if (upd_valid) begin
      if (u_hit) begin
        ctr[u_idx] <= upd_taken ? sat_inc(ctr[u_idx]) : sat_dec(ctr[u_idx]);
      end else if (upd_taken) begin
        valid[u_idx] <= 1'b1;
        ctr[u_idx]   <= 2'b10;
      end
    end
  end

  // Tag/target carry no reset; a taken update always (re)writes them, covering
  // both allocation and JALR retargeting on a hit.
  always_ff @(posedge clk) begin
    if (rst && upd_valid && upd_taken) begin
      tag[u_idx]    <= u_tag;
      target[u_idx] <= upd_target;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else if (upd_valid) begin
      stat_branches <= stat_branches + 32'd1;
      if (upd_mispredict) stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Randomized + directed bench for branch_predictor with a queue-based scoreboard
// and an abstract reference model keyed by word address.
module tb_branch_predictor;

  localparam int IDX_BITS = 6;
  localparam int ENTRIES  = 1 << IDX_BITS;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] query_pc;
  logic        pred_taken;
  logic [31:0] pred_pc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [31:0] upd_target;
  logic        upd_taken;
  logic        upd_mispredict;
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;

  branch_predictor #(.IDX_BITS(IDX_BITS)) dut (
    .clk(clk),
    .rst(rst),
    .query_pc(query_pc),
    .pred_taken(pred_taken),
    .pred_pc(pred_pc),
    .upd_valid(upd_valid),
    .upd_pc(upd_pc),
    .upd_target(upd_target),
    .upd_taken(upd_taken),
    .upd_mispredict(upd_mispredict),
    .stat_branches(stat_branches),
    .stat_mispredicts(stat_mispredicts)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        pt;
    logic [31:0] pp;
    logic [31:0] sb;
    logic [31:0] sm;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model: each slot remembers which word address owns it,
  // its target and a confidence level 0..3.
  bit          m_valid [ENTRIES];
  logic [31:0] m_owner [ENTRIES];
  logic [31:0] m_tgt   [ENTRIES];
  int          m_conf  [ENTRIES];
  logic [31:0] m_br;
  logic [31:0] m_mp;

  function automatic int slot(input logic [31:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction

  function automatic bit owns(input logic [31:0] pc);
    return m_valid[slot(pc)] && (m_owner[slot(pc)] == (pc >> 2));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 0;
      m_conf[i]  = 1;
    end
    m_br = 0;
    m_mp = 0;
  endtask

  task automatic model_update(input logic [31:0] pc, input logic [31:0] tgt,
                              input logic tk, input logic mp);
    int s;
    s = slot(pc);
    m_br = m_br + 1;
    if (mp) m_mp = m_mp + 1;
    if (owns(pc)) begin
      if (tk) begin
        m_conf[s] = (m_conf[s] >= 3) ? 3 : m_conf[s] + 1;
        m_tgt[s]  = tgt;
      end else begin
        m_conf[s] = (m_conf[s] <= 0) ? 0 : m_conf[s] - 1;
      end
    end else if (tk) begin
      m_valid[s] = 1;
      m_owner[s] = pc >> 2;
      m_tgt[s]   = tgt;
      m_conf[s]  = 2;
    end
  endtask

  // One cycle of stimulus: drive, record what the DUT must show this cycle,
  // then advance the model past the coming edge.
  task automatic step(input logic r, input logic [31:0] q, input logic uv,
                      input logic [31:0] upc, input logic [31:0] ut,
                      input logic tk, input logic mp);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; query_pc = q; upd_valid = uv; upd_pc = upc;
    upd_target = ut; upd_taken = tk; upd_mispredict = mp;
    e.sb = m_br;
    e.sm = m_mp;
    if (r && owns(q) && m_conf[slot(q)] >= 2) begin
      e.pt = 1'b1;
      e.pp = m_tgt[slot(q)];
    end else begin
      e.pt = 1'b0;
      e.pp = q + 32'd4;
    end
    exp_q.push_back(e);
    if (!r) model_reset();
    else if (uv) model_update(upc, ut, tk, mp);
  endtask

  task automatic query(input logic [31:0] q);
    step(1'b1, q, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic train(input logic [31:0] pc, input logic [31:0] tgt, input logic tk,
                       input logic mp);
    step(1'b1, pc, 1'b1, pc, tgt, tk, mp);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pred_taken", {31'b0, pred_taken}, {31'b0, e.pt});
        chk("pred_pc", pred_pc, e.pp);
        chk("stat_branches", stat_branches, e.sb);
        chk("stat_mispredicts", stat_mispredicts, e.sm);
      end
    end
  end

  function automatic logic [31:0] rand_pc();
    logic [31:0] p;
    if ($urandom_range(0, 15) == 0) begin
      p = $urandom;
    end else begin
      p = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2)
          | 32'($urandom_range(0, 3));
    end
    return p;
  endfunction

  initial begin : stimulus
    logic [31:0] p;
    rst = 1'b0; query_pc = 32'h0; upd_valid = 1'b0; upd_pc = 32'h0;
    upd_target = 32'h0; upd_taken = 1'b0; upd_mispredict = 1'b0;
    repeat (2) @(posedge clk);
    model_reset();

    query(32'h0000_0100);
    // Same-cycle query of the index being trained still sees the old entry.
    train(32'h100, 32'h200, 1'b1, 1'b1);
    query(32'h100);
    train(32'h100, 32'h200, 1'b1, 1'b0);
    train(32'h100, 32'h200, 1'b1, 1'b0);
    query(32'h100);
    train(32'h100, 32'h200, 1'b0, 1'b0);
    query(32'h100);
    train(32'h100, 32'h200, 1'b0, 1'b1);
    query(32'h100);
    train(32'h100, 32'h200, 1'b0, 1'b0);
    train(32'h100, 32'h200, 1'b0, 1'b0);
    train(32'h100, 32'h200, 1'b1, 1'b0);
    query(32'h100);
    train(32'h100, 32'h200, 1'b1, 1'b0);
    query(32'h100);
    train(32'h200, 32'h400, 1'b1, 1'b1);
    query(32'h100);
    query(32'h200);
    train(32'h300, 32'h800, 1'b0, 1'b0);
    query(32'h300);
    query(32'h200);
    query(32'hFFFF_FFFC);
    step(1'b0, 32'h200, 1'b1, 32'h200, 32'h500, 1'b1, 1'b1);
    query(32'h200);
    query(32'h200);

    for (int n = 0; n < 1500; n++) begin
      p = rand_pc();
      if ($urandom_range(0, 63) == 0) begin
        step(1'b0, p, $urandom_range(0, 1) == 1, rand_pc(), $urandom, 1'b1, 1'b1);
      end else if ($urandom_range(0, 2) != 0) begin
        step(1'b1, ($urandom_range(0, 1) == 1) ? p : rand_pc(), 1'b1, p, $urandom,
             $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1);
      end else begin
        query(p);
      end
    end

    @(posedge clk);
    #1;
    upd_valid = 1'b0;
    for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(negedge clk);
    @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
